eviction_tracker_drain_ctrl: RTL and testbench

//  Sequences the eviction status tracker buffer: owns its 32-bit config word, enables tracking, and drains
//  the buffer when the host requests it or the tracker stalls full. Reads each entry's
//  {status, trace} pair and presents it as a 32-bit word on a valid/ready stream to the perf-controller comm path.

---
 rtl/eviction_tracker_drain_ctrl.sv | 139 +++++++++++++
 tb/tb_eviction_tracker_drain_ctrl.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eviction_tracker_drain_ctrl.sv
// Drain sequencer for the eviction status tracker: owns its config word, walks the buffer
// entries onto a valid/ready stream, then clears the buffer and restores tracking.
module eviction_tracker_drain_ctrl #(
  parameter int unsigned COUNTER_BW    = 30,
  parameter int unsigned BW_BUFFER     = 12,
  parameter int unsigned OUT_SEL_WIDTH = 2,
  parameter int unsigned READ_LATENCY  = 2
) (
  input  logic                  clock_i,
  input  logic                  resetn_i,
  input  logic                  track_en_i,
  input  logic                  drain_req_i,
  input  logic                  tracker_stall_i,
  input  logic [31:0]           tracker_count_i,
  input  logic [COUNTER_BW-1:0] tracker_trace_i,
  input  logic [1:0]            tracker_status_i,
  output logic [31:0]           config_o,
  output logic [31:0]           data_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int unsigned WaitW      = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [31:0] Entries    = 32'd1 << BW_BUFFER;
  localparam logic [WaitW-1:0] WaitLast = WaitW'(READ_LATENCY - 1);
  localparam int unsigned AddrLo     = OUT_SEL_WIDTH;
  localparam int unsigned AddrHi     = BW_BUFFER - 1 + OUT_SEL_WIDTH;

  typedef enum logic [2:0] {StIdle, StFreeze, StAddr, StPush, StClear, StDone} state_e;

  state_e               state_q, state_d;
  logic [BW_BUFFER:0]   idx_q, idx_d;
  logic [BW_BUFFER:0]   cnt_q, cnt_d;
  logic [WaitW-1:0]     wait_q, wait_d;
  logic                 req_q, stall_q;
  logic [31:0]          config_q, config_d;
  logic [31:0]          data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 start;
  logic [31:0]          word;

  // Edges are only acted on in IDLE; the detectors keep tracking so a level held
  // across a drain never looks like a fresh edge afterwards.
  assign start = (drain_req_i & ~req_q) | (tracker_stall_i & ~stall_q & track_en_i);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    wait_d  = wait_q;
    data_d  = data_q;

    word = '0;
    word[31:30] = tracker_status_i;
    word[COUNTER_BW-1:0] = tracker_trace_i;

    unique case (state_q)
      StIdle: begin
        if (start) state_d = StFreeze;
      end
      StFreeze: begin
        cnt_d   = (tracker_count_i >= Entries) ? Entries[BW_BUFFER:0]
                                               : tracker_count_i[BW_BUFFER:0];
        idx_d   = '0;
        wait_d  = '0;
        state_d = (cnt_d == '0) ? StClear : StAddr;
      end
      StAddr: begin
        if (wait_q == WaitLast) begin
          data_d  = word;
          wait_d  = '0;
          state_d = StPush;
        end else begin
          wait_d = wait_q + WaitW'(1);
        end
      end
      StPush: begin
        if (valid_q && ready_i) begin
          idx_d   = idx_q + (BW_BUFFER + 1)'(1);
          state_d = (idx_d == cnt_q) ? StClear : StAddr;
        end
      end
      StClear: state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Outputs are registered from the next state so they line up with state_q.
    config_d = '0;
    unique case (state_d)
      StIdle, StDone: config_d[24] = track_en_i;
      StAddr:         config_d[AddrHi:AddrLo] = idx_d[BW_BUFFER-1:0];
      StClear:        config_d[23] = 1'b1;
      default:        config_d = '0;
    endcase
    valid_d = (state_d == StPush);
    busy_d  = state_d inside {StFreeze, StAddr, StPush, StClear};
    done_d  = (state_d == StDone);
  end

  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      cnt_q    <= '0;
      wait_q   <= '0;
      req_q    <= 1'b0;
      stall_q  <= 1'b0;
      config_q <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      wait_q   <= wait_d;
      req_q    <= drain_req_i;
      stall_q  <= tracker_stall_i;
      config_q <= config_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign config_o = config_q;
  assign data_o   = data_q;
  assign valid_o  = valid_q;
  assign busy_o   = busy_q;
  assign done_o   = done_q;

endmodule

// File: tb/tb_eviction_tracker_drain_ctrl.sv
// Bench for eviction_tracker_drain_ctrl: a tracker memory model plus a stream monitor,
// with expected words computed from the buffer contents and the drain length rule.
module tb_eviction_tracker_drain_ctrl;
  localparam int unsigned CBW = 30;
  localparam int unsigned BWB = 12;
  localparam int unsigned OSW = 2;
  localparam int unsigned RL  = 2;
  localparam int unsigned ENT = 4096;
  localparam int LIMIT = 40000;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic track_en = 1'b0, drain_req = 1'b0, stall = 1'b0, ready = 1'b0;
  logic [31:0] count = '0;
  logic [CBW-1:0] trace;
  logic [1:0] status;
  logic [31:0] cfg, data;
  logic valid, busy, done;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  eviction_tracker_drain_ctrl #(
    .COUNTER_BW(CBW), .BW_BUFFER(BWB), .OUT_SEL_WIDTH(OSW), .READ_LATENCY(RL)
  ) dut (
    .clock_i(clk), .resetn_i(resetn), .track_en_i(track_en), .drain_req_i(drain_req),
    .tracker_stall_i(stall), .tracker_count_i(count), .tracker_trace_i(trace),
    .tracker_status_i(status), .config_o(cfg), .data_o(data), .valid_o(valid),
    .ready_i(ready), .busy_o(busy), .done_o(done)
  );

  // Tracker buffer: read data shows up RL cycles after the address is first driven,
  // i.e. one register stage behind config_o for RL=2.
  logic [CBW-1:0] mem_trace [ENT];
  logic [1:0]     mem_status [ENT];
  logic [BWB-1:0] rd_addr;
  assign rd_addr = cfg[BWB-1+OSW:OSW];
  always @(posedge clk) begin
    trace  <= mem_trace[rd_addr];
    status <= mem_status[rd_addr];
  end

  // Stream / config monitor
  int beats, clear_cycles, done_pulses, cfg24_bad, hold_bad, stall_cycles, busy_cycles;
  logic [31:0] got [$];
  logic prev_vr;
  logic [31:0] prev_data;
  always @(negedge clk) begin
    if (valid && ready) begin
      got.push_back(data);
      beats++;
    end
    if (valid && !ready) stall_cycles++;
    if (prev_vr && !(valid && data == prev_data)) hold_bad++;
    prev_vr = valid && !ready;
    prev_data = data;
    if (cfg[23]) clear_cycles++;
    if (done) done_pulses++;
    if (busy && cfg[24]) cfg24_bad++;
    if (busy) busy_cycles++;
  end

  task automatic clear_mon();
    beats = 0; clear_cycles = 0; done_pulses = 0; cfg24_bad = 0;
    hold_bad = 0; stall_cycles = 0; busy_cycles = 0; prev_vr = 1'b0;
    got.delete();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_word(input int i);
    logic [31:0] w;
    w = '0;
    w[31:30] = mem_status[i];
    w = w | 32'(mem_trace[i]);
    return w;
  endfunction

  function automatic int exp_beats(input logic [31:0] c);
    return (c >= 32'(ENT)) ? ENT : int'(c);
  endfunction

  function automatic int count_bad(input int n);
    int bad = 0;
    for (int i = 0; i < n; i++) begin
      if (i >= got.size()) bad++;
      else if (got[i] !== exp_word(i)) bad++;
    end
    return bad;
  endfunction

  task automatic fill_random();
    for (int i = 0; i < ENT; i++) begin
      mem_trace[i]  = CBW'($urandom);
      mem_status[i] = 2'($urandom);
    end
  endtask

  // rmode: 0 ready high, 1 random ready, 2 ready low 10 cycles on beat 1,
  // 3 ready high plus edges/track_en changes injected during and at the end of the drain.
  task automatic run_drain(input logic [31:0] c, input bit via_stall, input int rmode,
                           output int cycles);
    int hold_left = 10;
    count = c;
    clear_mon();
    ready = (rmode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
    if (via_stall) stall = 1'b1;
    else drain_req = 1'b1;
    cycles = 0;
    while (!done && cycles < LIMIT) begin
      tick();
      cycles++;
      if (cycles == 1 && !via_stall) drain_req = 1'b0;
      case (rmode)
        1: ready = ($urandom_range(0, 3) != 0);
        2: begin
          if (valid && beats == 1 && hold_left > 0) begin
            ready = 1'b0;
            hold_left--;
          end else ready = 1'b1;
        end
        3: begin
          if (cycles == 5) drain_req = 1'b1;
          if (cycles == 6) stall = 1'b1;
          if (cycles == 7) drain_req = 1'b0;
          if (cycles == 8) track_en = 1'b0;
          if (cycles == 12) drain_req = 1'b1;
        end
        default: ready = 1'b1;
      endcase
    end
    n_cmp++;
    if (cycles >= LIMIT) begin
      n_fail++;
      $display("FAIL drain_timeout cycles=%0d limit=%0d", cycles, LIMIT);
    end
    tick();
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    track_en = 1'b1;
    tick(); tick();
    n_cmp++;
    if (cfg !== 32'h0 || valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || data !== 32'h0)
    begin
      n_fail++;
      $display("FAIL reset_outputs cfg=%h valid=%b busy=%b done=%b data=%h want all zero",
               cfg, valid, busy, done, data);
    end
    resetn = 1'b1;
    tick();
    n_cmp++;
    if (cfg !== 32'h0100_0000) begin
      n_fail++;
      $display("FAIL reset_track_cfg got %h want %h", cfg, 32'h0100_0000);
    end
    n_cmp++;
    if (valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle valid=%b busy=%b want 0 0", valid, busy);
    end
  endtask

  task automatic test_directed();
    int cyc;
    for (int i = 0; i < ENT; i++) begin
      mem_trace[i]  = CBW'(i + 5);
      mem_status[i] = 2'(i);
    end
    run_drain(32'd3, 1'b0, 0, cyc);
    n_cmp++;
    if (beats !== 3) begin
      n_fail++;
      $display("FAIL dir_beats got %0d want 3", beats);
    end
    n_cmp++;
    if (got.size() < 3 || got[0] !== 32'h0000_0005 || got[1] !== 32'h4000_0006 ||
        got[2] !== 32'h8000_0007) begin
      n_fail++;
      $display("FAIL dir_words got %p want 00000005 40000006 80000007", got);
    end
    n_cmp++;
    if (clear_cycles !== 1 || done_pulses !== 1) begin
      n_fail++;
      $display("FAIL dir_clear_done clear=%0d done=%0d want 1 1", clear_cycles, done_pulses);
    end
    n_cmp++;
    if (cfg !== 32'h0100_0000) begin
      n_fail++;
      $display("FAIL dir_cfg_after got %h want 01000000", cfg);
    end
    // freeze + 3 words of (RL address cycles + 1 push) + clear + done
    n_cmp++;
    if (cyc !== 1 + 3 * (RL + 1) + 2) begin
      n_fail++;
      $display("FAIL dir_latency got %0d want %0d", cyc, 1 + 3 * (RL + 1) + 2);
    end
  endtask

  task automatic test_empty();
    int cyc;
    run_drain(32'd0, 1'b0, 0, cyc);
    n_cmp++;
    if (beats !== 0) begin
      n_fail++;
      $display("FAIL empty_beats got %0d want 0", beats);
    end
    n_cmp++;
    if (cyc > 3) begin
      n_fail++;
      $display("FAIL empty_latency got %0d want <=3", cyc);
    end
    n_cmp++;
    if (clear_cycles !== 1 || done_pulses !== 1) begin
      n_fail++;
      $display("FAIL empty_clear_done clear=%0d done=%0d want 1 1", clear_cycles, done_pulses);
    end
  endtask

  task automatic test_full();
    int cyc;
    for (int i = 0; i < ENT; i++) begin
      mem_trace[i]  = CBW'(i);
      mem_status[i] = 2'($urandom);
    end
    stall = 1'b0;
    tick();
    run_drain(32'd4096, 1'b1, 0, cyc);
    n_cmp++;
    if (beats !== ENT || count_bad(ENT) !== 0) begin
      n_fail++;
      $display("FAIL full_words beats=%0d bad=%0d want %0d 0", beats, count_bad(ENT), ENT);
    end
    n_cmp++;
    if (cfg24_bad !== 0) begin
      n_fail++;
      $display("FAIL full_track_off got %0d busy cycles with bit24 want 0", cfg24_bad);
    end
    // Stall held high after the drain must not restart anything.
    clear_mon();
    repeat (20) tick();
    n_cmp++;
    if (busy_cycles !== 0) begin
      n_fail++;
      $display("FAIL stall_level_restart busy_cycles=%0d want 0", busy_cycles);
    end
    stall = 1'b0;
    tick();
    fill_random();
    run_drain(32'd9000, 1'b0, 1, cyc);
    n_cmp++;
    if (beats !== exp_beats(32'd9000) || count_bad(ENT) !== 0) begin
      n_fail++;
      $display("FAIL clip_words beats=%0d bad=%0d want %0d 0", beats, count_bad(ENT), ENT);
    end
  endtask

  task automatic test_backpressure();
    int cyc;
    fill_random();
    run_drain(32'd4, 1'b0, 2, cyc);
    n_cmp++;
    if (stall_cycles !== 10 || hold_bad !== 0) begin
      n_fail++;
      $display("FAIL bp_hold stalled=%0d unstable=%0d want 10 0", stall_cycles, hold_bad);
    end
    n_cmp++;
    if (beats !== 4 || count_bad(4) !== 0) begin
      n_fail++;
      $display("FAIL bp_words beats=%0d bad=%0d want 4 0", beats, count_bad(4));
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    fill_random();
    stall = 1'b0;
    tick();
    run_drain(32'd3, 1'b0, 3, cyc);
    repeat (15) tick();
    n_cmp++;
    if (done_pulses !== 1 || busy_cycles !== 1 + 3 * (RL + 1) + 1) begin
      n_fail++;
      $display("FAIL ignored_edges done=%0d busy=%0d want 1 %0d", done_pulses, busy_cycles,
               1 + 3 * (RL + 1) + 1);
    end
    n_cmp++;
    if (beats !== 3 || count_bad(3) !== 0) begin
      n_fail++;
      $display("FAIL b2b_words beats=%0d bad=%0d want 3 0", beats, count_bad(3));
    end
    n_cmp++;
    if (cfg !== 32'h0) begin
      n_fail++;
      $display("FAIL late_track_en cfg=%h want 00000000", cfg);
    end
    drain_req = 1'b0;
    stall = 1'b0;
    track_en = 1'b1;
    tick();
  endtask

  task automatic test_random();
    int cyc;
    logic [31:0] c;
    bit vs;
    for (int it = 0; it < 6; it++) begin
      fill_random();
      c = ($urandom_range(0, 4) == 0) ? 32'd0 : 32'($urandom_range(1, 40));
      vs = 1'($urandom);
      stall = 1'b0;
      tick();
      run_drain(c, vs, 1, cyc);
      n_cmp++;
      if (beats !== exp_beats(c) || count_bad(exp_beats(c)) !== 0) begin
        n_fail++;
        $display("FAIL rand_words it=%0d beats=%0d bad=%0d want %0d 0", it, beats,
                 count_bad(exp_beats(c)), exp_beats(c));
      end
      n_cmp++;
      if (done_pulses !== 1 || clear_cycles !== 1 || hold_bad !== 0 || cfg24_bad !== 0) begin
        n_fail++;
        $display("FAIL rand_ctrl it=%0d done=%0d clear=%0d unstable=%0d trk=%0d want 1 1 0 0",
                 it, done_pulses, clear_cycles, hold_bad, cfg24_bad);
      end
    end
    stall = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    int cyc;
    int w = 0;
    fill_random();
    count = 32'd5;
    ready = 1'b0;
    drain_req = 1'b1;
    tick();
    drain_req = 1'b0;
    while (!valid && w < 20) begin
      tick();
      w++;
    end
    n_cmp++;
    if (!valid) begin
      n_fail++;
      $display("FAIL mid_reach_push valid=%b want 1", valid);
    end
    resetn = 1'b0;
    #1;
    n_cmp++;
    if (valid !== 1'b0 || cfg !== 32'h0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset valid=%b cfg=%h busy=%b want 0 0 0", valid, cfg, busy);
    end
    tick();
    resetn = 1'b1;
    tick();
    run_drain(32'd5, 1'b0, 0, cyc);
    n_cmp++;
    if (beats !== 5 || count_bad(5) !== 0) begin
      n_fail++;
      $display("FAIL post_reset_words beats=%0d bad=%0d want 5 0", beats, count_bad(5));
    end
  endtask

  initial begin
    clear_mon();
    test_reset();
    test_directed();
    test_empty();
    test_full();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
